snail_rr_scheduler: RTL and testbench

- Shares one `fsm_moore_snail` pattern detector between two requesters.
- Each requester hands over a WORD_W-bit word through a valid/ready handshake.
- The block grants one requester, clears the detector, and shifts the word into it serially, MSB first.
- It counts the smiles caused by that word and returns the count with the requester ID through a valid/ready result port.

---
 rtl/snail_rr_scheduler.sv | 162 ++++++++++++++++
 tb/tb_snail_rr_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/snail_rr_scheduler.sv
`default_nettype none
// ============================================================================
// snail_rr_scheduler: arbitrates two requesters onto one Moore "01" detector,
// serialises each word MSB-first and returns the smile count with the owner ID.
// Option macro: SNAIL_SCHED_RR_EN (round-robin; fixed priority to req0 if undefined)
// Revision: 1.0
// ============================================================================
module snail_rr_scheduler #(
  parameter int WORD_W    = 8,
  parameter int SMILE_LAT = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         req0_valid_in,
  input  logic [WORD_W-1:0]            req0_word_in,
  output logic                         req0_ready_out,
  input  logic                         req1_valid_in,
  input  logic [WORD_W-1:0]            req1_word_in,
  output logic                         req1_ready_out,
  output logic                         snail_clr_out,
  output logic                         snail_seq_out,
  input  logic                         snail_smile_in,
  output logic                         done_valid_out,
  output logic                         done_id_out,
  output logic [$clog2(WORD_W+1)-1:0]  done_count_out,
  input  logic                         done_ready_in
);

  localparam int BIT_W      = $clog2(WORD_W);
  localparam int CNT_W      = $clog2(WORD_W + 1);
  localparam int DRAIN_W    = (SMILE_LAT > 2) ? $clog2(SMILE_LAT) : 1;
  localparam int DRAIN_LAST = (SMILE_LAT >= 2) ? SMILE_LAT - 2 : 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SHIFT  = 3'd2,
    DRAIN  = 3'd3,
    REPORT = 3'd4
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [WORD_W-1:0]     word_sh;
  logic                  id_q;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic [SMILE_LAT-1:0]  tags;
  logic [CNT_W-1:0]      count;
  logic                  seq_q;
  logic                  grant0;
  logic                  grant1;
  logic                  accept;

`ifdef SNAIL_SCHED_RR_EN
  logic ptr;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      grant1 = req1_valid_in && (!req0_valid_in || ptr);
      grant0 = req0_valid_in && !grant1;
    end
  end

  // Pointer names the requester that wins the next tie.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~grant1;
    end
  end
`else
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      grant0 = req0_valid_in;
      grant1 = req1_valid_in && !req0_valid_in;
    end
  end
`endif

  assign req0_ready_out = grant0;
  assign req1_ready_out = grant1;
  assign accept         = grant0 || grant1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CLEAR;
      CLEAR:   state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == BIT_W'(WORD_W - 1)) state_nxt = (SMILE_LAT > 1) ? DRAIN : REPORT;
      DRAIN:   if (drain_cnt == DRAIN_W'(DRAIN_LAST)) state_nxt = REPORT;
      REPORT:  if (done_ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // seq_q and tags[0] are loaded from state_nxt so they line up with the SHIFT cycles.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      word_sh   <= '0;
      id_q      <= 1'b0;
      bit_cnt   <= '0;
      drain_cnt <= '0;
      tags      <= '0;
      count     <= '0;
      seq_q     <= 1'b0;
    end else begin
      if (accept) begin
        word_sh <= grant1 ? req1_word_in : req0_word_in;
        id_q    <= grant1;
      end else if (state_nxt == SHIFT) begin
        word_sh <= word_sh << 1;
      end

      seq_q <= (state_nxt == SHIFT) && word_sh[WORD_W-1];

      if (state == SHIFT && state_nxt == SHIFT) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end else begin
        bit_cnt <= '0;
      end

      if (state == DRAIN && state_nxt == DRAIN) begin
        drain_cnt <= drain_cnt + DRAIN_W'(1);
      end else begin
        drain_cnt <= '0;
      end

      tags[0] <= (state_nxt == SHIFT);
      for (int i = 1; i < SMILE_LAT; i++) begin
        tags[i] <= tags[i-1];
      end

      if (state == CLEAR) begin
        count <= '0;
      end else if (tags[SMILE_LAT-1] && snail_smile_in) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  assign snail_clr_out  = (state == CLEAR);
  assign snail_seq_out  = seq_q;
  assign done_valid_out = (state == REPORT);
  assign done_id_out    = id_q;
  assign done_count_out = count;

endmodule
`default_nettype wire

// File: tb/tb_snail_rr_scheduler.sv
`default_nettype none
// ============================================================================
// tb_snail_rr_scheduler: drives snail_rr_scheduler with a behavioural "01"
// Moore detector and checks grants, serial timing and smile counts.
// Revision: 1.0
// ============================================================================
module tb_snail_rr_scheduler;

  logic       clk;
  logic       rst;
  logic       v0, v1, r0, r1;
  logic [7:0] w0, w1;
  logic       clr, seq, smile;
  logic       dv, did, dready;
  logic [3:0] dcnt;

  int n_cmp  = 0;
  int n_fail = 0;
  logic m_ptr = 1'b0;

  snail_rr_scheduler #(.WORD_W(8), .SMILE_LAT(2)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .req0_valid_in  (v0),
    .req0_word_in   (w0),
    .req0_ready_out (r0),
    .req1_valid_in  (v1),
    .req1_word_in   (w1),
    .req1_ready_out (r1),
    .snail_clr_out  (clr),
    .snail_seq_out  (seq),
    .snail_smile_in (smile),
    .done_valid_out (dv),
    .done_id_out    (did),
    .done_count_out (dcnt),
    .done_ready_in  (dready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Moore "01" detector, reset by the scheduler's clear: 0=idle, 1=seen 0, 2=smile.
  logic [1:0] det = 2'd0;
  assign smile = (det == 2'd2);
  always @(posedge clk or posedge clr) begin
    if (clr) det <= 2'd0;
    else if (seq) det <= (det == 2'd1) ? 2'd2 : 2'd0;
    else det <= 2'd1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_smiles(input logic [7:0] w);
    int n = 0;
    for (int i = 7; i > 0; i--) if (!w[i] && w[i-1]) n++;
    return n;
  endfunction

  function automatic logic model_winner(input logic a0, input logic a1);
`ifdef SNAIL_SCHED_RR_EN
    if (a0 && a1) return m_ptr;
`endif
    return a0 ? 1'b0 : 1'b1;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_ptr = 1'b0;
    tick();
  endtask

  // One full transaction: grant, CLEAR, 8 bits, drain, REPORT with optional stall.
  task automatic txn(input logic a0, input logic [7:0] d0, input logic a1, input logic [7:0] d1,
                     input logic exp_id, input int exp_cnt, input int stall);
    logic [7:0] w;
    int hold_cnt;
    logic hold_id;
    v0 = a0; w0 = d0; v1 = a1; w1 = d1; dready = 1'b1;
    #1;
    check("ready0_at_idle", r0, exp_id == 1'b0);
    check("ready1_at_idle", r1, exp_id == 1'b1);
    w = exp_id ? d1 : d0;
    for (int n = 1; n <= 11; n++) begin
      tick();
      if (n == 1) begin
        if (exp_id) v1 = 1'b0; else v0 = 1'b0;
        #1;
      end
      check($sformatf("clr@%0d", n), clr, n == 1);
      check($sformatf("seq@%0d", n), seq, (n >= 2 && n <= 9) ? int'(w[9-n]) : 0);
      check($sformatf("done_valid@%0d", n), dv, n == 11);
      check($sformatf("readies@%0d", n), {r0, r1}, 0);
    end
    check("done_id", did, exp_id);
    check("done_count", dcnt, exp_cnt);
    hold_id = did;
    hold_cnt = dcnt;
    if (stall > 0) begin
      dready = 1'b0;
      for (int s = 1; s <= stall; s++) begin
        tick();
        check($sformatf("stall_valid@%0d", s), dv, 1);
        check($sformatf("stall_id@%0d", s), did, hold_id);
        check($sformatf("stall_count@%0d", s), dcnt, hold_cnt);
        check($sformatf("stall_readies@%0d", s), {r0, r1}, 0);
      end
      dready = 1'b1;
    end
    tick();
    check("done_valid_after_hs", dv, 0);
    m_ptr = ~exp_id;
  endtask

  typedef struct {
    logic       a0;
    logic [7:0] d0;
    logic       a1;
    logic [7:0] d1;
    logic       id;
    int         cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic ra0, ra1, eid;
    logic [7:0] rd0, rd1;
    logic [3:0] exp_rr [4];
    int seen_dv;

    tbl[0] = '{1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 4};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 0};
    tbl[3] = '{1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, 3};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 8'h0F, 1'b1, 1};
    tbl[5] = '{1'b1, 8'h96, 1'b0, 8'h00, 1'b0, 2};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 8'h81, 1'b1, 1};

    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; w0 = 8'h00; w1 = 8'h00; dready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_clr", clr, 0);
    check("rst_seq", seq, 0);
    check("rst_done_valid", dv, 0);
    check("rst_done_id", did, 0);
    check("rst_done_count", dcnt, 0);
    check("rst_readies", {r0, r1}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    check("idle_readies", {r0, r1}, 0);
    check("idle_done_valid", dv, 0);
    check("idle_clr", clr, 0);

    for (int i = 0; i < 7; i++)
      txn(tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1, tbl[i].id, tbl[i].cnt, 0);

    // Tie arbitration from a fresh pointer.
    do_reset();
`ifdef SNAIL_SCHED_RR_EN
    exp_rr = '{4'd0, 4'd1, 4'd0, 4'd1};
`else
    exp_rr = '{4'd0, 4'd0, 4'd0, 4'd0};
`endif
    for (int i = 0; i < 4; i++) begin
      eid = model_winner(1'b1, 1'b1);
      check($sformatf("tie_model@%0d", i), eid, exp_rr[i]);
      txn(1'b1, 8'h01, 1'b1, 8'h03, exp_rr[i][0], 1, 0);
    end

    // REPORT stall with the losing requester still waiting, then serve it.
    eid = model_winner(1'b1, 1'b1);
    txn(1'b1, 8'h3C, 1'b1, 8'h5A, eid, ref_smiles(eid ? 8'h5A : 8'h3C), 5);
    if (eid) txn(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, ref_smiles(8'h3C), 0);
    else     txn(1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, ref_smiles(8'h5A), 0);

    // Reset asserted while bit 4 is on the wire.
    v0 = 1'b1; w0 = 8'h36; v1 = 1'b0; dready = 1'b1;
    tick();
    v0 = 1'b0;
    repeat (5) tick();
    check("mid_seq_bit4", seq, int'(w0[3]));
    #2 rst = 1'b0;
    #1;
    check("mid_rst_clr", clr, 0);
    check("mid_rst_seq", seq, 0);
    check("mid_rst_done_valid", dv, 0);
    check("mid_rst_done_id", did, 0);
    check("mid_rst_done_count", dcnt, 0);
    check("mid_rst_readies", {r0, r1}, 0);
    @(negedge clk);
    rst = 1'b1;
    m_ptr = 1'b0;
    seen_dv = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (dv) seen_dv++;
    end
    check("no_result_after_rst", seen_dv, 0);
    txn(1'b1, 8'h36, 1'b0, 8'h00, 1'b0, ref_smiles(8'h36), 0);

    // Randomised traffic against the arbitration and smile models.
    for (int i = 0; i < 24; i++) begin
      ra0 = 1'($urandom_range(0, 1));
      ra1 = 1'($urandom_range(0, 1));
      if (!ra0 && !ra1) ra1 = 1'b1;
      rd0 = 8'($urandom);
      rd1 = 8'($urandom);
      eid = model_winner(ra0, ra1);
      txn(ra0, rd0, ra1, rd1, eid, ref_smiles(eid ? rd1 : rd0), $urandom_range(0, 2));
    end

    v0 = 1'b0; v1 = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
